ddr_ctl1_arbiter: RTL and testbench



---
 rtl/ddr_ctl1_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_ctl1_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ctl1_arbiter.sv
// Two-port round-robin front end for a DdrCtl1 controller: serialises page
// reads/writes into LCK/LAx/LDx/ULK/WRP|RDP instruction bursts and acks the requester.

`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LCK 4'h1
`define DdrCtl1_ULK 4'h2
`define DdrCtl1_LA0 4'h3
`define DdrCtl1_LA1 4'h4
`define DdrCtl1_LA2 4'h5
`define DdrCtl1_LA3 4'h6
`define DdrCtl1_LD0 4'h7
`define DdrCtl1_LD1 4'h8
`define DdrCtl1_LD2 4'h9
`define DdrCtl1_LD3 4'hA
`define DdrCtl1_WRP 4'hB
`define DdrCtl1_RDP 4'hC
`endif

module ddr_ctl1_arbiter #(
    parameter int unsigned timeout_cycles = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req0_ack,
    output logic        req1_ack,
    output logic [31:0] req0_rdata,
    output logic [31:0] req1_rdata,
    output logic [11:0] ctl_inst,
    output logic        ctl_inst_en,
    input  logic [31:0] ctl_page,
    input  logic        ctl_ready,
    output logic        busy,
    output logic        grant,
    output logic        error
);

    localparam int unsigned CW_RAW = $clog2(timeout_cycles + 1);
    localparam int unsigned CW     = (CW_RAW > 10) ? CW_RAW : 10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        DRAIN,
        WAIT_DONE,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          win_q, win_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [11:0]   inst_q, inst_d;
    logic          inst_en_q, inst_en_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          grant_q, grant_d;

    logic [11:0]   seq_inst;
    logic [3:0]    last_step;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    assign last_step   = write_q ? 4'd10 : 4'd6;
    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (cnt_inc == CW'(timeout_cycles));

    // Steps 5 and 6 are shared: data loads for a write, ULK/RDP for a read.
    always_comb begin
        seq_inst = {`DdrCtl1_NOP, 8'h00};
        case (step_q)
            4'd0:    seq_inst = {`DdrCtl1_LCK, 8'h00};
            4'd1:    seq_inst = {`DdrCtl1_LA0, addr_q[7:0]};
            4'd2:    seq_inst = {`DdrCtl1_LA1, addr_q[15:8]};
            4'd3:    seq_inst = {`DdrCtl1_LA2, addr_q[23:16]};
            4'd4:    seq_inst = {`DdrCtl1_LA3, addr_q[31:24]};
            4'd5:    seq_inst = write_q ? {`DdrCtl1_LD0, wdata_q[7:0]} : {`DdrCtl1_ULK, 8'h00};
            4'd6:    seq_inst = write_q ? {`DdrCtl1_LD1, wdata_q[15:8]} : {`DdrCtl1_RDP, 8'h00};
            4'd7:    seq_inst = {`DdrCtl1_LD2, wdata_q[23:16]};
            4'd8:    seq_inst = {`DdrCtl1_LD3, wdata_q[31:24]};
            4'd9:    seq_inst = {`DdrCtl1_ULK, 8'h00};
            4'd10:   seq_inst = {`DdrCtl1_WRP, 8'h00};
            default: seq_inst = {`DdrCtl1_NOP, 8'h00};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        inst_d    = {`DdrCtl1_NOP, 8'h00};
        inst_en_d = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        busy_d    = (state_q != IDLE);
        grant_d   = (state_q != IDLE) ? win_q : 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    win_d = (req0_valid && req1_valid) ? ptr_q : req1_valid;
                    if (win_d) begin
                        write_d = req1_write;
                        addr_d  = req1_addr;
                        wdata_d = req1_wdata;
                    end else begin
                        write_d = req0_write;
                        addr_d  = req0_addr;
                        wdata_d = req0_wdata;
                    end
                    cnt_d   = '0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (ctl_ready) begin
                    step_d  = '0;
                    state_d = ISSUE;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    if (win_q) rdata1_d = '0;
                    else       rdata0_d = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ISSUE: begin
                inst_d    = seq_inst;
                inst_en_d = 1'b1;
                if (step_q == last_step) state_d = DRAIN;
                else                     step_d  = step_q + 4'd1;
            end
            DRAIN: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ctl_ready) begin
                    if (!write_q) begin
                        if (win_q) rdata1_d = ctl_page;
                        else       rdata0_d = ctl_page;
                    end
                    state_d = ACK;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    if (win_q) rdata1_d = '0;
                    else       rdata0_d = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK: begin
                if (win_q) ack1_d = 1'b1;
                else       ack0_d = 1'b1;
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            inst_q    <= {`DdrCtl1_NOP, 8'h00};
            inst_en_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            inst_q    <= inst_d;
            inst_en_q <= inst_en_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
        end
    end

    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign ctl_inst    = inst_q;
    assign ctl_inst_en = inst_en_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign error       = err_q;

endmodule

// File: tb/tb_ddr_ctl1_arbiter.sv
// Scoreboard bench for ddr_ctl1_arbiter: a DdrCtl1 behavioural model feeds the DUT,
// a round-robin reference predicts each transaction and a monitor checks it on ack.

module tb_ddr_ctl1_arbiter;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LCK = 4'h1;
    localparam logic [3:0] OP_ULK = 4'h2;
    localparam logic [3:0] OP_LA0 = 4'h3;
    localparam logic [3:0] OP_LD0 = 4'h7;
    localparam logic [3:0] OP_LD1 = 4'h8;
    localparam logic [3:0] OP_WRP = 4'hB;
    localparam logic [3:0] OP_RDP = 4'hC;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0]  r_valid, r_write;
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata[2];
    logic        ack0, ack1, ctl_inst_en, busy, grant, err;
    logic [31:0] rd0, rd1, ctl_page;
    logic [11:0] ctl_inst;
    logic        ctl_ready;

    ddr_ctl1_arbiter dut (
        .clock(clock), .reset(rst_n),
        .req0_valid(r_valid[0]), .req0_write(r_write[0]), .req0_addr(r_addr[0]), .req0_wdata(r_wdata[0]),
        .req1_valid(r_valid[1]), .req1_write(r_write[1]), .req1_addr(r_addr[1]), .req1_wdata(r_wdata[1]),
        .req0_ack(ack0), .req1_ack(ack1), .req0_rdata(rd0), .req1_rdata(rd1),
        .ctl_inst(ctl_inst), .ctl_inst_en(ctl_inst_en), .ctl_page(ctl_page), .ctl_ready(ctl_ready),
        .busy(busy), .grant(grant), .error(err)
    );

    // Second instance with a short timeout for the stalled-controller scenario.
    logic [1:0]  t_valid;
    logic [31:0] t_addr, t_page;
    logic        t_ready, t_ack0, t_ack1, t_inst_en, t_busy, t_grant, t_err;
    logic [31:0] t_rd0, t_rd1;
    logic [11:0] t_inst;

    ddr_ctl1_arbiter #(.timeout_cycles(15)) dut_to (
        .clock(clock), .reset(rst_n),
        .req0_valid(t_valid[0]), .req0_write(1'b0), .req0_addr(t_addr), .req0_wdata(32'h0),
        .req1_valid(t_valid[1]), .req1_write(1'b0), .req1_addr(t_addr), .req1_wdata(32'h0),
        .req0_ack(t_ack0), .req1_ack(t_ack1), .req0_rdata(t_rd0), .req1_rdata(t_rd1),
        .ctl_inst(t_inst), .ctl_inst_en(t_inst_en), .ctl_page(t_page), .ctl_ready(t_ready),
        .busy(t_busy), .grant(t_grant), .error(t_err)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_exp;
        int          start;
        int          delay;
    } txn_t;

    txn_t        exp_q[$];
    int          delay_q[$];
    int          ack_log[$];
    logic [11:0] got_q[$];
    logic [31:0] refmem[logic [31:0]];
    logic [31:0] ctlmem[logic [31:0]];
    logic [31:0] exp_rd[2];
    int          force_delay = 0;
    int          first_cyc, last_cyc;

    function automatic logic [31:0] mem_default(logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [11:0] exp_inst(txn_t t, int i);
        if (i == 0) return {OP_LCK, 8'h00};
        if (i <= 4) return {OP_LA0 + 4'(i - 1), t.addr[8*(i-1) +: 8]};
        if (t.wr) begin
            if (i <= 8) return {OP_LD0 + 4'(i - 5), t.wdata[8*(i-5) +: 8]};
            if (i == 9) return {OP_ULK, 8'h00};
            return {OP_WRP, 8'h00};
        end
        if (i == 5) return {OP_ULK, 8'h00};
        return {OP_RDP, 8'h00};
    endfunction

    // Reference model + monitor: round-robin choice at each idle edge, full check at each ack.
    initial begin : model
        bit   idle;
        int   ptr;
        idle = 1'b1;
        ptr  = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!rst_n) begin
                idle = 1'b1;
                ptr  = 0;
                exp_q.delete();
                delay_q.delete();
                got_q.delete();
                exp_rd[0] = '0;
                exp_rd[1] = '0;
                continue;
            end
            if (ctl_inst_en) begin
                if (got_q.size() == 0) first_cyc = cyc;
                got_q.push_back(ctl_inst);
                last_cyc = cyc;
            end else begin
                check("nop_when_disabled", ctl_inst, {OP_NOP, 8'h00});
            end
            if (!idle && exp_q.size() > 0 && cyc == exp_q[0].start + 1)
                check("busy_after_grant", busy, 1);
            if (ack0 || ack1) begin
                check("ack_exclusive", ack0 & ack1, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {ack1, ack0}, 2'b00);
                end else begin
                    txn_t t;
                    int   n;
                    t = exp_q.pop_front();
                    n = t.wr ? 11 : 7;
                    check("ack_port", ack1 ? 1 : 0, t.port);
                    check("grant_at_ack", grant, t.port);
                    check("busy_at_ack", busy, 1);
                    check("error_clear", err, 0);
                    check("seq_len", got_q.size(), n);
                    for (int i = 0; i < n && i < got_q.size(); i++)
                        check("seq_inst", got_q[i], exp_inst(t, i));
                    check("first_inst_cycle", first_cyc, t.start + 2);
                    check("last_inst_cycle", last_cyc, t.start + 1 + n);
                    check("ack_cycle", cyc, t.start + 1 + n + ((t.delay + 2 > 3) ? t.delay + 2 : 3));
                    if (t.wr) refmem[t.addr] = t.wdata;
                    else      exp_rd[t.port] = t.rd_exp;
                    check("rdata0", rd0, exp_rd[0]);
                    check("rdata1", rd1, exp_rd[1]);
                    ack_log.push_back(t.port);
                    ptr = 1 - t.port;
                end
                got_q.delete();
                idle = 1'b1;
            end else if (idle && r_valid != 2'b00) begin
                txn_t t;
                t.port   = (r_valid == 2'b11) ? ptr : (r_valid[1] ? 1 : 0);
                t.wr     = r_write[t.port];
                t.addr   = r_addr[t.port];
                t.wdata  = r_wdata[t.port];
                t.rd_exp = refmem.exists(t.addr) ? refmem[t.addr] : mem_default(t.addr);
                t.start  = cyc;
                t.delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 12));
                check("busy_low_at_grant", busy, 0);
                delay_q.push_back(t.delay);
                exp_q.push_back(t);
                got_q.delete();
                idle = 1'b0;
            end
        end
    end

    // DdrCtl1 behavioural model: decodes the instruction stream, busy for a chosen delay after WRP/RDP.
    initial begin : ctl_model
        logic [31:0] ca, cd, result;
        int          left;
        bit          pending;
        ctl_ready = 1'b1;
        ctl_page  = '0;
        ca = '0; cd = '0; result = '0; left = 0; pending = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (rst_n && ctl_inst_en) begin
                case (ctl_inst[11:8])
                    4'h3, 4'h4, 4'h5, 4'h6: ca[8*(ctl_inst[11:8] - OP_LA0) +: 8] = ctl_inst[7:0];
                    4'h7, 4'h8, 4'h9, 4'hA: cd[8*(ctl_inst[11:8] - OP_LD0) +: 8] = ctl_inst[7:0];
                    OP_WRP, OP_RDP: begin
                        if (ctl_inst[11:8] == OP_WRP) begin
                            ctlmem[ca] = cd;
                            result = $urandom;
                        end else begin
                            result = ctlmem.exists(ca) ? ctlmem[ca] : mem_default(ca);
                        end
                        left    = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                        pending = 1'b1;
                    end
                    default: ;
                endcase
            end
            @(negedge clock);
            if (!rst_n) begin
                ctl_ready = 1'b1;
                pending   = 1'b0;
            end else if (pending) begin
                if (left > 0) begin
                    ctl_ready = 1'b0;
                    ctl_page  = $urandom;
                    left--;
                end else begin
                    ctl_ready = 1'b1;
                    ctl_page  = result;
                    pending   = 1'b0;
                end
            end
        end
    end

    task automatic do_req(int p, bit wr, logic [31:0] a, logic [31:0] d);
        @(negedge clock);
        r_write[p] = wr;
        r_addr[p]  = a;
        r_wdata[p] = d;
        r_valid[p] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ((p == 0) ? ack0 : ack1) break;
        end
        check("ack_seen", (p == 0) ? ack0 : ack1, 1);
        r_valid[p] = 1'b0;
    endtask

    task automatic t_wait(output int port, output int at, output int en_cnt);
        port = -1; at = 0; en_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #1;
            if (t_inst_en) en_cnt++;
            if (t_ack0 || t_ack1) begin
                port = t_ack1 ? 1 : 0;
                at   = cyc;
                break;
            end
        end
        check("t_ack_seen", t_ack0 | t_ack1, 1);
    endtask

    logic [31:0] addrs[4];

    initial begin : stim
        int port, at, en_cnt, s;
        addrs[0] = 32'h002B_3F12;
        addrs[1] = 32'h012B_3F12;
        addrs[2] = 32'h8000_0004;
        addrs[3] = 32'hFFFF_FFFF;
        refmem[32'h012B_3F12] = 32'h2211_FFEE;
        ctlmem[32'h012B_3F12] = 32'h2211_FFEE;
        rst_n = 1'b0;
        r_valid = '0; r_write = '0;
        r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
        t_valid = '0; t_addr = 32'h0000_0040; t_page = '0; t_ready = 1'b1;
        #2;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_inst_en", ctl_inst_en, 0);
        check("rst_inst", ctl_inst, {OP_NOP, 8'h00});
        check("rst_error", err, 0);
        check("rst_rdata0", rd0, 0);
        check("rst_rdata1", rd1, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;

        // Both requesters at once from reset, requester 0 asking twice.
        force_delay = 0;
        ack_log.delete();
        fork
            begin
                do_req(0, 1'b1, 32'h8000_0004, 32'hA5A5_0001);
                do_req(0, 1'b0, 32'h8000_0004, 32'h0);
            end
            do_req(1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        join
        check("rr_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            check("rr_first", ack_log[0], 0);
            check("rr_second", ack_log[1], 1);
            check("rr_third", ack_log[2], 0);
        end

        // Directed write with ready always high, then a read with a 30-cycle busy controller.
        do_req(0, 1'b1, 32'h002B_3F12, 32'hDDCC_BBAA);
        force_delay = 30;
        do_req(1, 1'b0, 32'h012B_3F12, 32'h0);
        check("read_page_rdata1", rd1, 32'h2211_FFEE);
        force_delay = 0;

        // Reset in the middle of a write burst.
        @(negedge clock);
        r_write[0] = 1'b1; r_addr[0] = 32'h0000_0100; r_wdata[0] = 32'h0BAD_F00D; r_valid[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (ctl_inst_en && ctl_inst[11:8] == OP_LD1) break;
        end
        check("saw_ld1", ctl_inst[11:8], OP_LD1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_inst_en", ctl_inst_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_inst", ctl_inst, {OP_NOP, 8'h00});
        @(negedge clock);
        r_valid[0] = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        do_req(0, 1'b1, 32'h8000_0004, 32'h1122_3344);

        // Randomised concurrent traffic.
        force_delay = -1;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                do_req(0, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                do_req(1, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom);
            end
        join
        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);

        // Short-timeout instance: good read, stalled read, then both pending.
        @(negedge clock);
        t_ready = 1'b1; t_page = 32'hCAFE_F00D; t_valid[0] = 1'b1;
        t_wait(port, at, en_cnt);
        check("t_ok_port", port, 0);
        check("t_ok_rdata0", t_rd0, 32'hCAFE_F00D);
        check("t_ok_error", t_err, 0);
        @(negedge clock);
        t_valid[0] = 1'b0;
        repeat (2) @(negedge clock);
        t_ready = 1'b0; t_valid[0] = 1'b1;
        s = cyc + 1;
        t_wait(port, at, en_cnt);
        check("t_to_port", port, 0);
        check("t_to_ack_cycle", at, s + 16);
        check("t_to_no_inst", en_cnt, 0);
        check("t_to_rdata0", t_rd0, 0);
        check("t_to_error", t_err, 1);
        @(negedge clock);
        t_valid[0] = 1'b0;
        repeat (2) @(negedge clock);
        t_ready = 1'b1; t_page = 32'h1357_2468; t_valid = 2'b11;
        t_wait(port, at, en_cnt);
        check("t_ptr_moved_port", port, 1);
        check("t_after_rdata1", t_rd1, 32'h1357_2468);
        check("t_sticky_error1", t_err, 1);
        @(negedge clock);
        t_valid[1] = 1'b0;
        t_wait(port, at, en_cnt);
        check("t_second_port", port, 0);
        check("t_second_rdata0", t_rd0, 32'h1357_2468);
        check("t_sticky_error2", t_err, 1);
        @(negedge clock);
        t_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t_error_reset", t_err, 0);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
